// File: rtl/fpnew_pkg.sv
//------------------------------------------------------------------------------
// Module      : fpnew_pkg
// Description : Shared FPU operation, format, rounding-mode and status types.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

`default_nettype wire

// File: rtl/fpnew_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : fpnew_rr_arbiter
// Description : Requester select; round-robin when FPNEW_DIVSQRT_ARB_RR_EN is
//               defined, otherwise fixed priority (lowest index wins).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpnew_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         valid_i,
  input  logic                      advance_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      any_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);

  logic [IdxWidth-1:0] w_idx;
  logic                w_any;

`ifdef FPNEW_DIVSQRT_ARB_RR_EN
  logic [IdxWidth-1:0] r_last;
  logic [IdxWidth:0]   w_cand;

  // Scan starts just after the last winner and wraps at NumReq.
  always_comb begin
    w_idx  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      w_cand = {1'b0, r_last} + (IdxWidth+1)'(k);
      if (w_cand >= (IdxWidth+1)'(NumReq)) w_cand = w_cand - (IdxWidth+1)'(NumReq);
      if (!w_any && valid_i[w_cand[IdxWidth-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_cand[IdxWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_last <= IdxWidth'(NumReq - 1);
    else if (advance_i) r_last <= w_idx;
  end
`else
  logic w_unused;
  assign w_unused = ^{clk_i, rst_ni, advance_i};

  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_any && valid_i[k]) begin
        w_any = 1'b1;
        w_idx = IdxWidth'(k);
      end
    end
  end
`endif

  assign idx_o = w_idx;
  assign any_o = w_any;
  assign gnt_o = w_any ? (NumReq'(1) << w_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/fpnew_divsqrt_arbiter.sv
//------------------------------------------------------------------------------
// Module      : fpnew_divsqrt_arbiter
// Description : Shares one divsqrt unit among NumReq requesters, one op in
//               flight. Macro FPNEW_DIVSQRT_ARB_RR_EN selects round-robin.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpnew_divsqrt_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TagWidth = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][1:0][WIDTH-1:0]    req_operands_i,
  input  operation_e [NumReq-1:0]              req_op_i,
  input  fp_format_e [NumReq-1:0]              req_fmt_i,
  input  roundmode_e [NumReq-1:0]              req_rnd_i,
  input  logic [NumReq-1:0][TagWidth-1:0]      req_tag_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [WIDTH-1:0]                     rsp_result_o,
  output status_t                              rsp_status_o,
  output logic [TagWidth-1:0]                  rsp_tag_o,
  output logic                                 unit_valid_o,
  input  logic                                 unit_ready_i,
  output logic [1:0][WIDTH-1:0]                unit_operands_o,
  output operation_e                           unit_op_o,
  output fp_format_e                           unit_fmt_o,
  output roundmode_e                           unit_rnd_o,
  input  logic                                 unit_valid_i,
  output logic                                 unit_ready_o,
  input  logic [WIDTH-1:0]                     unit_result_i,
  input  status_t                              unit_status_i,
  input  logic                                 flush_i,
  output logic                                 unit_flush_o,
  output logic                                 busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  arb_state_e            r_state, w_state_next;
  logic [NumReq-1:0]     w_gnt;
  logic [IdxWidth-1:0]   w_idx;
  logic                  w_any;
  logic                  w_accept, w_capture;

  logic [IdxWidth-1:0]   r_owner;
  logic [1:0][WIDTH-1:0] r_operands;
  operation_e            r_op;
  fp_format_e            r_fmt;
  roundmode_e            r_rnd;
  logic [TagWidth-1:0]   r_tag;
  logic [WIDTH-1:0]      r_result;
  status_t               r_status;
  logic [TagWidth-1:0]   r_rsp_tag;

  fpnew_rr_arbiter #(.NumReq(NumReq)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (req_valid_i),
    .advance_i (w_accept),
    .gnt_o     (w_gnt),
    .idx_o     (w_idx),
    .any_o     (w_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    unit_valid_o = 1'b0;
    unit_ready_o = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        unit_ready_o = 1'b1;  // drain and discard stray results
        if (w_any) begin
          req_ready_o  = w_gnt;
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid_o = 1'b1;
        if (unit_ready_i) w_state_next = WAIT;
      end
      WAIT: begin
        unit_ready_o = 1'b1;
        if (unit_valid_i) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[r_owner] = 1'b1;
        if (rsp_ready_i[r_owner]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // A kill suppresses every handshake and leaves the arbiter pointer alone.
    if (flush_i) begin
      w_state_next = IDLE;
      req_ready_o  = '0;
      rsp_valid_o  = '0;
      unit_valid_o = 1'b0;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner    <= '0;
      r_operands <= '0;
      r_op       <= FMADD;
      r_fmt      <= FP32;
      r_rnd      <= RNE;
      r_tag      <= '0;
      r_result   <= '0;
      r_status   <= '0;
      r_rsp_tag  <= '0;
    end else begin
      if (w_accept) begin
        r_owner    <= w_idx;
        r_operands <= req_operands_i[w_idx];
        r_op       <= req_op_i[w_idx];
        r_fmt      <= req_fmt_i[w_idx];
        r_rnd      <= req_rnd_i[w_idx];
        r_tag      <= req_tag_i[w_idx];
      end
      if (w_capture) begin
        r_result  <= unit_result_i;
        r_status  <= unit_status_i;
        r_rsp_tag <= r_tag;
      end
    end
  end

  assign unit_operands_o = r_operands;
  assign unit_op_o       = r_op;
  assign unit_fmt_o      = r_fmt;
  assign unit_rnd_o      = r_rnd;
  assign rsp_result_o    = r_result;
  assign rsp_status_o    = r_status;
  assign rsp_tag_o       = r_rsp_tag;
  assign unit_flush_o    = flush_i;
  assign busy_o          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpnew_divsqrt_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_fpnew_divsqrt_arbiter
// Description : Self-checking bench with a transaction-level reference model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fpnew_divsqrt_arbiter;
  import fpnew_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TW = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]              req_valid_i, req_ready_o;
  logic [N-1:0][1:0][W-1:0]  req_operands_i;
  operation_e [N-1:0]        req_op_i;
  fp_format_e [N-1:0]        req_fmt_i;
  roundmode_e [N-1:0]        req_rnd_i;
  logic [N-1:0][TW-1:0]      req_tag_i;
  logic [N-1:0]              rsp_valid_o, rsp_ready_i;
  logic [W-1:0]              rsp_result_o;
  status_t                   rsp_status_o;
  logic [TW-1:0]             rsp_tag_o;
  logic                      unit_valid_o, unit_ready_i;
  logic [1:0][W-1:0]         unit_operands_o;
  operation_e                unit_op_o;
  fp_format_e                unit_fmt_o;
  roundmode_e                unit_rnd_o;
  logic                      unit_valid_i, unit_ready_o;
  logic [W-1:0]              unit_result_i;
  status_t                   unit_status_i;
  logic                      flush_i, unit_flush_o, busy_o;

  fpnew_divsqrt_arbiter #(.NumReq(N), .WIDTH(W), .TagWidth(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i), .req_fmt_i(req_fmt_i),
    .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o), .unit_fmt_o(unit_fmt_o),
    .unit_rnd_o(unit_rnd_o), .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
    .unit_result_i(unit_result_i), .unit_status_i(unit_status_i),
    .flush_i(flush_i), .unit_flush_o(unit_flush_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference model: phase 0 idle, 1 issuing, 2 waiting on unit, 3 responding.
  int                m_phase, m_owner, m_last, s_grant;
  logic [1:0][W-1:0] m_ops;
  logic [3:0]        m_op;
  logic [2:0]        m_fmt, m_rnd;
  logic [TW-1:0]     m_tag, m_rtag;
  logic [W-1:0]      m_res;
  logic [4:0]        m_stat;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = N - 1;
    m_ops = '0; m_op = '0; m_fmt = '0; m_rnd = '0;
    m_tag = '0; m_rtag = '0; m_res = '0; m_stat = '0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
`ifdef FPNEW_DIVSQRT_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int j = 0; j < N; j++) if (v[j]) return j;
`endif
    return -1;
  endfunction

  task automatic sample();
    @(negedge clk_i);
    s_grant = (m_phase == 0 && !flush_i) ? pick(req_valid_i) : -1;
    check("req_ready", req_ready_o, (s_grant >= 0) ? (1 << s_grant) : 0);
    check("rsp_valid", rsp_valid_o, (m_phase == 3 && !flush_i) ? (1 << m_owner) : 0);
    check("unit_valid", unit_valid_o, m_phase == 1 && !flush_i);
    if (!flush_i) check("unit_ready", unit_ready_o, m_phase == 0 || m_phase == 2);
    check("busy", busy_o, m_phase != 0);
    check("unit_flush", unit_flush_o, flush_i);
    check("unit_operands", unit_operands_o, m_ops);
    check("unit_ctl", {unit_op_o, unit_fmt_o, unit_rnd_o}, {m_op, m_fmt, m_rnd});
    check("rsp_data", {rsp_result_o, rsp_status_o, rsp_tag_o}, {m_res, m_stat, m_rtag});
  endtask

  task automatic advance();
    if (flush_i) m_phase = 0;
    else case (m_phase)
      0: if (s_grant >= 0) begin
        m_owner = s_grant; m_last = s_grant;
        m_ops = req_operands_i[s_grant]; m_op = req_op_i[s_grant];
        m_fmt = req_fmt_i[s_grant]; m_rnd = req_rnd_i[s_grant]; m_tag = req_tag_i[s_grant];
        m_phase = 1;
      end
      1: if (unit_ready_i) m_phase = 2;
      2: if (unit_valid_i) begin
        m_res = unit_result_i; m_stat = unit_status_i; m_rtag = m_tag; m_phase = 3;
      end
      default: if (rsp_ready_i[m_owner]) m_phase = 0;
    endcase
    @(posedge clk_i); #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_operands_i[i] = {$urandom, $urandom, $urandom, $urandom};
      req_op_i[i]       = ($urandom % 2) ? DIV : SQRT;
      req_fmt_i[i]      = fp_format_e'($urandom_range(0, 4));
      req_rnd_i[i]      = roundmode_e'($urandom_range(0, 4));
      req_tag_i[i]      = TW'($urandom);
    end
    unit_result_i = {$urandom, $urandom};
    unit_status_i = status_t'(5'($urandom));
  endtask

  task automatic quiet();
    req_valid_i = '0; rsp_ready_i = '0; unit_ready_i = 1'b0;
    unit_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  int grants[$];
  int exp_order[5];

  initial begin
    rst_ni = 1'b0;
    quiet();
    rand_data();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ctl", {req_ready_o, rsp_valid_o, unit_valid_o, unit_ready_o, busy_o},
          {4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    check("rst_data", {unit_operands_o, rsp_tag_o}, '0);
    rst_ni = 1'b1;

    // Single request from requester 2, unit answers after 10 cycles.
    req_valid_i = 4'b0100; req_op_i[2] = DIV; req_tag_i[2] = 8'h5A;
    sample(); check("sr_grant", req_ready_o, 4'b0100); advance();
    req_valid_i = '0;
    sample(); check("sr_issue", unit_valid_o, 1'b1); advance();
    unit_ready_i = 1'b1; step(); unit_ready_i = 1'b0;
    repeat (9) step();
    unit_valid_i = 1'b1; step(); unit_valid_i = 1'b0;
    sample();
    check("sr_rsp", rsp_valid_o, 4'b0100);
    check("sr_tag", rsp_tag_o, 8'h5A);
    rsp_ready_i = 4'b0100; advance(); rsp_ready_i = '0;
    step();

    // Response backpressure on requester 1 while everyone else requests.
    req_valid_i = 4'b0010; unit_ready_i = 1'b1; unit_valid_i = 1'b1;
    step(); req_valid_i = '0; step(); step();
    req_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      sample();
      check("bp_valid", rsp_valid_o, 4'b0010);
      check("bp_busy", busy_o, 1'b1);
      check("bp_data", rsp_result_o, m_res);
      advance();
    end
    req_valid_i = '0; rsp_ready_i = 4'b0010; step(); quiet(); step();

    // Unit stall in ISSUE for 3 cycles.
    req_valid_i = 4'b1000; step(); req_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      sample();
      check("stall_ops", unit_operands_o, m_ops);
      check("stall_valid", unit_valid_o, 1'b1);
      advance();
    end
    unit_ready_i = 1'b1; step(); unit_ready_i = 1'b0;
    sample(); check("stall_wait", {unit_valid_o, unit_ready_o}, 2'b01); advance();
    unit_valid_i = 1'b1; step(); unit_valid_i = 1'b0;
    rsp_ready_i = 4'b1111; step(); quiet();

    // Flush while waiting for the unit; the late result must be drained.
    req_valid_i = 4'b0100; unit_ready_i = 1'b1; step(); req_valid_i = '0;
    step(); unit_ready_i = 1'b0; step();
    flush_i = 1'b1;
    sample(); check("fl_unit_flush", unit_flush_o, 1'b1); advance();
    flush_i = 1'b0; unit_valid_i = 1'b1;
    sample(); check("fl_drain", {rsp_valid_o, unit_ready_o}, 5'b00001); advance();
    unit_valid_i = 1'b0;
    sample(); check("fl_norsp", {rsp_valid_o, busy_o}, 5'b0); advance();

    // Asynchronous reset while requester 0 is in RESP.
    req_valid_i = 4'b0001; unit_ready_i = 1'b1; unit_valid_i = 1'b1;
    step(); req_valid_i = '0; step(); step(); step();
    quiet();
    #2 rst_ni = 1'b0;
    #1;
    check("amr_ctl", {req_ready_o, rsp_valid_o, unit_valid_o, unit_ready_o, busy_o},
          {4'b0, 4'b0, 1'b0, 1'b1, 1'b0});
    check("amr_data", {unit_operands_o, rsp_result_o, rsp_tag_o}, '0);
    model_reset();
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // All four requesting continuously with an always-ready unit and consumers.
`ifdef FPNEW_DIVSQRT_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    req_valid_i = 4'b1111; unit_ready_i = 1'b1; unit_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      sample();
      for (int i = 0; i < N; i++) if (req_ready_o[i]) grants.push_back(i);
      advance();
    end
    check("rr_count", grants.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) check("rr_order", grants[i], exp_order[i]);
    quiet();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rand_data();
      req_valid_i  = N'($urandom);
      unit_ready_i = 1'($urandom);
      unit_valid_i = 1'($urandom);
      rsp_ready_i  = N'($urandom);
      flush_i      = ($urandom % 16) == 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
